// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment frame receiver.
// Active-low segment patterns (bit0=a .. bit6=g) as driven by the hex encoders,
// plus the receiver FSM state encoding.
package seg7_pkg;

  // Active-low glyph patterns, one per hex digit.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational lookup: active-low 7-segment pattern -> {known, nibble}.
// Ports: i_seg (pattern in), o_known (pattern is a valid digit), o_nibble (decoded value,
// 0 when unknown). Config macro SEG7_BLANK_DIGIT_EN: blank pattern decodes as known zero.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_known,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_known  = 1'b1;
    o_nibble = 4'h0;
    case (i_seg)
      SEG_0: o_nibble = 4'h0;
      SEG_1: o_nibble = 4'h1;
      SEG_2: o_nibble = 4'h2;
      SEG_3: o_nibble = 4'h3;
      SEG_4: o_nibble = 4'h4;
      SEG_5: o_nibble = 4'h5;
      SEG_6: o_nibble = 4'h6;
      SEG_7: o_nibble = 4'h7;
      SEG_8: o_nibble = 4'h8;
      SEG_9: o_nibble = 4'h9;
      SEG_A: o_nibble = 4'hA;
      SEG_B: o_nibble = 4'hB;
      SEG_C: o_nibble = 4'hC;
      SEG_D: o_nibble = 4'hD;
      SEG_E: o_nibble = 4'hE;
      SEG_F: o_nibble = 4'hF;
`ifdef SEG7_BLANK_DIGIT_EN
      // Leading-blank displays read as zero without flagging the frame.
      SEG_BLANK: o_nibble = 4'h0;
`endif
      default: begin
        o_known  = 1'b0;
        o_nibble = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_frame_reader.sv
// Receiver for 7-segment digit streams: decodes each pattern and assembles a frame
// (first digit most significant), then offers it until the consumer accepts it.
// Ports: i_clk, i_rst (sync, active-high), i_seg_in/i_seg_valid/i_seg_last (digit stream),
// i_value_ready (consumer accept); o_value/o_value_valid/o_digit_count/o_frame_bad/
// o_frame_long (offered frame), o_overrun (pulse: digit dropped while holding a frame).
// Config macro SEG7_BLANK_DIGIT_EN (in seg7_pattern_decoder): blank pattern reads as 0.
module seg7_frame_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [6:0]                   i_seg_in,
  input  logic                         i_seg_valid,
  input  logic                         i_seg_last,
  input  logic                         i_value_ready,
  output logic [4*DIGITS-1:0]          o_value,
  output logic                         o_value_valid,
  output logic [$clog2(DIGITS+1)-1:0]  o_digit_count,
  output logic                         o_frame_bad,
  output logic                         o_frame_long,
  output logic                         o_overrun
);

  localparam int VW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  state_t          r_state;
  logic [VW-1:0]   r_value;
  logic            r_value_valid;
  logic [CW-1:0]   r_count;
  logic            r_bad;
  logic            r_long;
  logic            r_overrun;

  logic            w_known;
  logic [3:0]      w_nibble;

  seg7_pattern_decoder u_dec (
    .i_seg    (i_seg_in),
    .o_known  (w_known),
    .o_nibble (w_nibble)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_COLLECT;
      r_value       <= '0;
      r_value_valid <= 1'b0;
      r_count       <= '0;
      r_bad         <= 1'b0;
      r_long        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (i_seg_valid) begin
            r_value <= {r_value[VW-5:0], w_nibble};
            if (!w_known) r_bad <= 1'b1;
            // At capacity the oldest digit falls off the top; remember that it happened.
            if (r_count == CW'(DIGITS)) r_long <= 1'b1;
            else                        r_count <= r_count + 1'b1;
            if (i_seg_last) begin
              r_state       <= ST_HOLD;
              r_value_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Frame is frozen; any digit arriving now is lost.
          if (i_seg_valid) r_overrun <= 1'b1;
          if (i_value_ready) begin
            // Clearing here makes the next short frame read with zero upper digits.
            r_state       <= ST_COLLECT;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_count       <= '0;
            r_bad         <= 1'b0;
            r_long        <= 1'b0;
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign o_value       = r_value;
  assign o_value_valid = r_value_valid;
  assign o_digit_count = r_count;
  assign o_frame_bad   = r_bad;
  assign o_frame_long  = r_long;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_seg7_frame_reader.sv
module tb_seg7_frame_reader;

  localparam int DIGITS = 6;
`ifdef SEG7_BLANK_DIGIT_EN
  localparam logic BLANK_BAD = 1'b0;
`else
  localparam logic BLANK_BAD = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic        seg_valid, seg_last, value_ready;
  logic [23:0] value;
  logic        value_valid;
  logic [2:0]  digit_count;
  logic        frame_bad, frame_long, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg7_frame_reader #(.DIGITS(DIGITS)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_seg_in      (seg_in),
    .i_seg_valid   (seg_valid),
    .i_seg_last    (seg_last),
    .i_value_ready (value_ready),
    .o_value       (value),
    .o_value_valid (value_valid),
    .o_digit_count (digit_count),
    .o_frame_bad   (frame_bad),
    .o_frame_long  (frame_long),
    .o_overrun     (overrun)
  );

  // One row: inputs applied for one clock, outputs expected just after that edge.
  typedef struct {
    logic        rst;
    logic [6:0]  seg;
    logic        vld;
    logic        last;
    logic        rdy;
    logic [23:0] val;
    logic        ovld;
    logic [2:0]  cnt;
    logic        bad;
    logic        lng;
    logic        ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [6:0] s, input logic v, input logic l,
                     input logic rd, input logic [23:0] ev, input logic eov,
                     input logic [2:0] ec, input logic eb, input logic el, input logic eo);
    vec_t t;
    t.rst = r; t.seg = s; t.vld = v; t.last = l; t.rdy = rd;
    t.val = ev; t.ovld = eov; t.cnt = ec; t.bad = eb; t.lng = el; t.ovr = eo;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [6:0] s, input logic v, input logic l,
                       input logic rd);
    rst = r; seg_in = s; seg_valid = v; seg_last = l; value_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [23:0] ev, input logic eov,
                         input logic [2:0] ec, input logic eb, input logic el, input logic eo);
    chk({tag, ".value"},       32'(value),       32'(ev));
    chk({tag, ".value_valid"}, 32'(value_valid), 32'(eov));
    chk({tag, ".digit_count"}, 32'(digit_count), 32'(ec));
    chk({tag, ".frame_bad"},   32'(frame_bad),   32'(eb));
    chk({tag, ".frame_long"},  32'(frame_long),  32'(el));
    chk({tag, ".overrun"},     32'(overrun),     32'(eo));
  endtask

  initial begin
    // Full 6-digit frame, then accept.
    add(0, 7'h79, 1, 0, 0, 24'h000001, 0, 1, 0, 0, 0);
    add(0, 7'h24, 1, 0, 0, 24'h000012, 0, 2, 0, 0, 0);
    add(0, 7'h30, 1, 0, 1, 24'h000123, 0, 3, 0, 0, 0); // ready in COLLECT ignored
    add(0, 7'h19, 1, 0, 0, 24'h001234, 0, 4, 0, 0, 0);
    add(0, 7'h00, 0, 1, 0, 24'h001234, 0, 4, 0, 0, 0); // last without valid ignored
    add(0, 7'h12, 1, 0, 0, 24'h012345, 0, 5, 0, 0, 0);
    add(0, 7'h02, 1, 1, 0, 24'h123456, 1, 6, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 24'h000000, 0, 0, 0, 0, 0);
    // Bad pattern in the middle.
    add(0, 7'h79, 1, 0, 0, 24'h000001, 0, 1, 0, 0, 0);
    add(0, 7'h55, 1, 0, 0, 24'h000010, 0, 2, 1, 0, 0);
    add(0, 7'h30, 1, 1, 0, 24'h000103, 1, 3, 1, 0, 0);
    add(0, 7'h00, 0, 0, 1, 24'h000000, 0, 0, 0, 0, 0);
    // Blank pattern, single-digit frame.
    add(0, 7'h7F, 1, 1, 0, 24'h000000, 1, 1, BLANK_BAD, 0, 0);
    add(0, 7'h00, 0, 0, 1, 24'h000000, 0, 0, 0, 0, 0);
    // Eight digits 0..7: oldest two fall off.
    add(0, 7'h40, 1, 0, 0, 24'h000000, 0, 1, 0, 0, 0);
    add(0, 7'h79, 1, 0, 0, 24'h000001, 0, 2, 0, 0, 0);
    add(0, 7'h24, 1, 0, 0, 24'h000012, 0, 3, 0, 0, 0);
    add(0, 7'h30, 1, 0, 0, 24'h000123, 0, 4, 0, 0, 0);
    add(0, 7'h19, 1, 0, 0, 24'h001234, 0, 5, 0, 0, 0);
    add(0, 7'h12, 1, 0, 0, 24'h012345, 0, 6, 0, 0, 0);
    add(0, 7'h02, 1, 0, 0, 24'h123456, 0, 6, 0, 1, 0);
    add(0, 7'h78, 1, 1, 0, 24'h234567, 1, 6, 0, 1, 0);
    add(0, 7'h00, 0, 0, 1, 24'h000000, 0, 0, 0, 0, 0);
    // Digits during HOLD, incl. same cycle as the handshake, are dropped.
    add(0, 7'h79, 1, 1, 0, 24'h000001, 1, 1, 0, 0, 0);
    add(0, 7'h24, 1, 0, 0, 24'h000001, 1, 1, 0, 0, 1);
    add(0, 7'h30, 1, 1, 1, 24'h000000, 0, 0, 0, 0, 1);
    add(0, 7'h00, 0, 0, 0, 24'h000000, 0, 0, 0, 0, 0);
    add(0, 7'h19, 1, 1, 0, 24'h000004, 1, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 24'h000000, 0, 0, 0, 0, 0);
    // Back-to-back: next digit in the cycle right after the handshake.
    add(0, 7'h46, 1, 1, 0, 24'h00000C, 1, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 24'h000000, 0, 0, 0, 0, 0);
    add(0, 7'h0E, 1, 1, 0, 24'h00000F, 1, 1, 0, 0, 0);
    add(0, 7'h00, 0, 0, 1, 24'h000000, 0, 0, 0, 0, 0);

    // Reset and initial state.
    drive(1, 7'h00, 0, 0, 0);
    drive(1, 7'h00, 0, 0, 0);
    chk_all("reset", 24'h0, 0, 0, 0, 0, 0);
    drive(0, 7'h00, 0, 0, 0);
    chk_all("idle", 24'h0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].seg, vecs[i].vld, vecs[i].last, vecs[i].rdy);
      chk_all($sformatf("vec%0d", i), vecs[i].val, vecs[i].ovld, vecs[i].cnt,
              vecs[i].bad, vecs[i].lng, vecs[i].ovr);
    end

    // Reset mid-frame after three digits, then a clean frame.
    drive(0, 7'h79, 1, 0, 0);
    drive(0, 7'h24, 1, 0, 0);
    drive(0, 7'h55, 1, 0, 0);
    chk_all("pre_rst", 24'h000120, 0, 3, 1, 0, 0);
    drive(1, 7'h30, 1, 1, 0);
    chk_all("mid_rst", 24'h0, 0, 0, 0, 0, 0);
    drive(0, 7'h19, 1, 1, 0);
    chk_all("post_rst", 24'h000004, 1, 1, 0, 0, 0);

    // Reset while holding a frame, with a digit arriving.
    drive(1, 7'h24, 1, 0, 0);
    chk_all("hold_rst", 24'h0, 0, 0, 0, 0, 0);

    // Short frame held for five cycles without ready.
    drive(0, 7'h08, 1, 0, 0);
    drive(0, 7'h03, 1, 1, 0);
    chk_all("short", 24'h0000AB, 1, 2, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 7'h00, 0, 0, 0);
      chk_all($sformatf("stable%0d", k), 24'h0000AB, 1, 2, 0, 0, 0);
    end
    drive(0, 7'h00, 0, 0, 1);
    chk_all("short_ack", 24'h0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
